// File: rtl/draw_cell_overlay_if.sv
// Pixel stream bundle for the VGA overlay chain: beam position, sync, blanking and colour.
// master drives the stream, slave consumes it; there is no backpressure.
interface draw_cell_overlay_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cell_overlay.sv
// N x N board-cell painter driven by a frame-synchronous 2-bit state per cell.
// Latency 2 pclk on every output; no backpressure, one pixel accepted per clock.
module draw_cell_overlay #(
  parameter int          GRID_N       = 3,
  parameter int          GRID_X0      = 0,
  parameter int          GRID_Y0      = 0,
  parameter int          CELL_W       = 341,
  parameter int          CELL_H       = 256,
  parameter int          MARGIN       = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COL_P1       = 12'hF00,
  parameter logic [11:0] COL_P2       = 12'h00F,
  parameter logic [11:0] COL_HL       = 12'hFF0
) (
  input  logic                         pclk,
  input  logic                         rst,
  draw_cell_overlay_if.slave           in_bus,
  draw_cell_overlay_if.master          out_bus,
  input  logic [2*GRID_N*GRID_N-1:0]   cell_state
);

  localparam int NCELL = GRID_N * GRID_N;
  localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

  function automatic logic [10:0] x_lo(input int c);
    return 11'(GRID_X0 + c * CELL_W + MARGIN);
  endfunction
  function automatic logic [10:0] x_hi(input int c);
    return 11'(GRID_X0 + (c + 1) * CELL_W - 1 - MARGIN);
  endfunction
  function automatic logic [10:0] y_lo(input int r);
    return 11'(GRID_Y0 + r * CELL_H + MARGIN);
  endfunction
  function automatic logic [10:0] y_hi(input int r);
    return 11'(GRID_Y0 + (r + 1) * CELL_H - 1 - MARGIN);
  endfunction

  logic             col_hit, row_hit;
  logic [1:0]       col_idx, row_idx;
  logic [3:0]       cell_idx;

  logic             s1_in_cell;
  logic [3:0]       s1_idx;
  logic [11:0]      s1_rgb;
  logic [10:0]      s1_hcount, s1_vcount;
  logic             s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;

  logic [1:0]       shadow [NCELL];
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;
  logic             vsync_prev;
  logic             vsync_rise;
  logic [11:0]      paint;

  // Bounds are constants, so each column/row test is just a pair of comparators.
  always_comb begin
    col_hit = 1'b0;
    row_hit = 1'b0;
    col_idx = 2'd0;
    row_idx = 2'd0;
    for (int c = 0; c < GRID_N; c++) begin
      if (in_bus.hcount >= x_lo(c) && in_bus.hcount <= x_hi(c)) begin
        col_hit = 1'b1;
        col_idx = 2'(c);
      end
    end
    for (int r = 0; r < GRID_N; r++) begin
      if (in_bus.vcount >= y_lo(r) && in_bus.vcount <= y_hi(r)) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
    cell_idx = {2'b00, row_idx} * 4'(GRID_N) + {2'b00, col_idx};
  end

  assign vsync_rise = in_bus.vsync & ~vsync_prev;

  always_comb begin
    paint = s1_rgb;
    if (s1_in_cell && !s1_hblnk && !s1_vblnk) begin
      case (shadow[s1_idx])
        2'b01:   paint = COL_P1;
        2'b10:   paint = COL_P2;
        2'b11:   paint = blink_phase ? COL_HL : s1_rgb;
        default: paint = s1_rgb;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_in_cell     <= 1'b0;
      s1_idx         <= 4'd0;
      s1_rgb         <= 12'd0;
      s1_hcount      <= 11'd0;
      s1_vcount      <= 11'd0;
      s1_hsync       <= 1'b0;
      s1_vsync       <= 1'b0;
      s1_hblnk       <= 1'b0;
      s1_vblnk       <= 1'b0;
      out_bus.hcount <= 11'd0;
      out_bus.vcount <= 11'd0;
      out_bus.hsync  <= 1'b0;
      out_bus.vsync  <= 1'b0;
      out_bus.hblnk  <= 1'b0;
      out_bus.vblnk  <= 1'b0;
      out_bus.rgb    <= 12'd0;
      for (int k = 0; k < NCELL; k++) shadow[k] <= 2'b00;
      frame_cnt      <= '0;
      blink_phase    <= 1'b1;
      vsync_prev     <= 1'b0;
    end else begin
      s1_in_cell     <= col_hit & row_hit;
      s1_idx         <= cell_idx;
      s1_rgb         <= in_bus.rgb;
      s1_hcount      <= in_bus.hcount;
      s1_vcount      <= in_bus.vcount;
      s1_hsync       <= in_bus.hsync;
      s1_vsync       <= in_bus.vsync;
      s1_hblnk       <= in_bus.hblnk;
      s1_vblnk       <= in_bus.vblnk;

      out_bus.hcount <= s1_hcount;
      out_bus.vcount <= s1_vcount;
      out_bus.hsync  <= s1_hsync;
      out_bus.vsync  <= s1_vsync;
      out_bus.hblnk  <= s1_hblnk;
      out_bus.vblnk  <= s1_vblnk;
      out_bus.rgb    <= paint;

      vsync_prev     <= in_bus.vsync;
      // Board state is only sampled at the frame edge so a cell never tears.
      if (vsync_rise) begin
        for (int k = 0; k < NCELL; k++) shadow[k] <= cell_state[2*k +: 2];
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt   <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_cell_overlay.sv
// Randomized and directed bench for draw_cell_overlay against a division-based pixel model.
module tb_draw_cell_overlay;
  localparam int N  = 3;
  localparam int X0 = 0;
  localparam int Y0 = 0;
  localparam int CW = 341;
  localparam int CH = 256;
  localparam int MG = 4;
  localparam int BF = 2;
  localparam logic [11:0] P1 = 12'hF00;
  localparam logic [11:0] P2 = 12'h00F;
  localparam logic [11:0] HL = 12'hFF0;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [17:0] cs_cur = '0;

  draw_cell_overlay_if in_if ();
  draw_cell_overlay_if out_if ();

  draw_cell_overlay #(
    .GRID_N(N), .GRID_X0(X0), .GRID_Y0(Y0), .CELL_W(CW), .CELL_H(CH),
    .MARGIN(MG), .BLINK_FRAMES(BF), .COL_P1(P1), .COL_P2(P2), .COL_HL(HL)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .in_bus     (in_if),
    .out_bus    (out_if),
    .cell_state (cs_cur)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the board looks like this frame, and the blink schedule.
  int          m_shadow [N*N];
  int          m_cnt;
  bit          m_phase;
  bit          m_prev;
  logic [37:0] m_s1, m_out;

  task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_colour(input int h, input int v, input bit hb,
                                             input bit vb, input logic [11:0] rgb);
    int cx, cy, ox, oy;
    if (hb || vb || h < X0 || v < Y0) return rgb;
    cx = (h - X0) / CW;  ox = (h - X0) % CW;
    cy = (v - Y0) / CH;  oy = (v - Y0) % CH;
    if (cx >= N || cy >= N) return rgb;
    if (ox < MG || ox > CW - 1 - MG || oy < MG || oy > CH - 1 - MG) return rgb;
    case (m_shadow[cy * N + cx])
      1:       return P1;
      2:       return P2;
      3:       return m_phase ? HL : rgb;
      default: return rgb;
    endcase
  endfunction

  function automatic logic [37:0] out_vec();
    return {out_if.hcount, out_if.vcount, out_if.hsync, out_if.vsync,
            out_if.hblnk, out_if.vblnk, out_if.rgb};
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (m_shadow[k]) m_shadow[k] = 0;
      m_cnt = 0; m_phase = 1'b1; m_prev = 1'b0;
      m_s1 = '0; m_out = '0;
    end else begin
      if (in_if.vsync && !m_prev) begin
        for (int k = 0; k < N*N; k++) m_shadow[k] = int'(cs_cur[2*k +: 2]);
        if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
        else m_cnt++;
      end
      m_prev = in_if.vsync;
      m_out  = m_s1;
      m_s1   = {in_if.hcount, in_if.vcount, in_if.hsync, in_if.vsync, in_if.hblnk,
                in_if.vblnk, ref_colour(int'(in_if.hcount), int'(in_if.vcount),
                                        in_if.hblnk, in_if.vblnk, in_if.rgb)};
    end
  endtask

  task automatic step(input logic r, input logic [10:0] h, input logic [10:0] v,
                      input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic [11:0] rgb);
    @(negedge pclk);
    rst = r;
    in_if.hcount = h; in_if.vcount = v; in_if.hsync = hs; in_if.vsync = vs;
    in_if.hblnk = hb; in_if.vblnk = vb; in_if.rgb = rgb;
    @(posedge pclk);
    model_edge();
    #1;
    chk("cycle", out_vec(), m_out);
  endtask

  // Present one pixel for two clocks, then check its painted colour.
  task automatic probe(input string tag, input int h, input int v, input bit hb,
                       input bit pass_rgb, input logic [11:0] want);
    logic [11:0] r;
    r = 12'($urandom);
    step(1'b0, 11'(h), 11'(v), 1'b0, 1'b0, hb, 1'b0, r);
    step(1'b0, 11'(h), 11'(v), 1'b0, 1'b0, hb, 1'b0, r);
    chk(tag, {26'd0, out_if.rgb}, {26'd0, pass_rgb ? r : want});
  endtask

  task automatic vsync_pulse();
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'($urandom));
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'($urandom));
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'($urandom));
  endtask

  task automatic do_reset(input int cycles, input bit noisy);
    for (int i = 0; i < cycles; i++)
      step(1'b1, noisy ? 11'($urandom) : 11'd0, noisy ? 11'($urandom) : 11'd0,
           noisy ? 1'($urandom) : 1'b0, noisy ? 1'($urandom) : 1'b0,
           noisy ? 1'($urandom) : 1'b0, noisy ? 1'($urandom) : 1'b0,
           noisy ? 12'($urandom) : 12'd0);
  endtask

  initial begin
    bit vs_state;
    bit exp_hl;

    // Reset with random inputs and random board state.
    cs_cur = 18'($urandom);
    do_reset(3, 1'b1);
    chk("rst_out", out_vec(), 38'd0);
    cs_cur = '0;
    probe("rst_release", int'($urandom_range(0, 1000)), int'($urandom_range(0, 700)),
          1'b0, 1'b1, 12'd0);

    // Ramp with empty cells: every output is the input delayed two clocks.
    for (int i = 0; i < 40; i++)
      step(1'b0, 11'(i * 7), 11'(i), 1'(i), 1'b0, 1'(i >> 2), 1'b0, 12'(i * 13));

    // Cell 1 = P1.
    cs_cur = 18'h00004;
    vsync_pulse();
    probe("paint_in",     400, 100, 1'b0, 1'b0, P1);
    probe("paint_margin", 344, 100, 1'b0, 1'b1, 12'd0);
    probe("paint_row1",   400, 300, 1'b0, 1'b1, 12'd0);

    // Cell 4 = P2 requested mid-frame; only visible after the next frame edge.
    cs_cur[9:8] = 2'b10;
    probe("sync_hold", 512, 384, 1'b0, 1'b1, 12'd0);
    vsync_pulse();
    probe("sync_new",  512, 384, 1'b0, 1'b0, P2);

    // Cell 0 highlight: phase after k frame edges is 1 xor (number of toggles) mod 2.
    cs_cur[1:0] = 2'b11;
    do_reset(2, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      vsync_pulse();
      exp_hl = ((k / BF) % 2) == 0;
      probe("blink", 100, 100, 1'b0, !exp_hl, HL);
    end
    do_reset(2, 1'b0);
    probe("blink_rst_empty", 100, 100, 1'b0, 1'b1, 12'd0);
    vsync_pulse();
    probe("blink_restart", 100, 100, 1'b0, 1'b0, HL);

    // Blanking overrides a painted cell.
    probe("hblank",   400, 100, 1'b1, 1'b1, 12'd0);
    probe("no_blank", 400, 100, 1'b0, 1'b0, P1);

    // Random traffic, random board changes, frame edges and occasional resets.
    vs_state = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) cs_cur = 18'($urandom);
      if ($urandom_range(0, 29) == 0) vs_state = ~vs_state;
      step(1'($urandom_range(0, 299) == 0),
           11'($urandom_range(0, 1200)), 11'($urandom_range(0, 820)),
           1'($urandom), vs_state,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
           12'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
